// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM states, bubble encoding, default reset PC.
package if_stage_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } if_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Instruction addresses are word aligned; drop the two LSBs.
    function automatic logic [31:0] pc_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush (bubble) beats load, load beats hold.
module if_id_reg
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc4_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    // Bubble on reset/flush, capture on load, otherwise keep contents.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            instr_q <= NOP;
            pc4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc4_q   <= pc4_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, memory request FSM, stall hold buffer, IF/ID feed.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc_plus4,
    output logic        id_valid
);

    if_state_e   state_q, state_d;
    // pc_q is always the address on the bus; in DRAIN the redirect target
    // waits in tgt_q so the outstanding request keeps its address.
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] hb_instr_q, hb_instr_d;
    logic [31:0] hb_pc4_q, hb_pc4_d;
    logic        hb_vld_q, hb_vld_d;

    logic        flush, load;
    logic [31:0] ld_instr, ld_pc4;
    logic [31:0] pc_inc;

    assign pc_inc    = pc_q + 32'd4;
    assign imem_req  = (state_q != HOLD) && !reset;
    assign imem_addr = pc_q;

    // Next-state, PC, hold buffer and IF/ID controls; redirect dominates.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        tgt_d      = tgt_q;
        hb_instr_d = hb_instr_q;
        hb_pc4_d   = hb_pc4_q;
        hb_vld_d   = hb_vld_q;
        flush      = 1'b0;
        load       = 1'b0;
        ld_instr   = imem_rdata;
        ld_pc4     = pc_inc;
        unique case (state_q)
            FETCH: begin
                if (redirect) begin
                    flush    = 1'b1;
                    hb_vld_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = pc_align(redirect_pc);
                    end else begin
                        tgt_d   = pc_align(redirect_pc);
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_inc;
                    if (!stall_id || !id_valid) begin
                        load = 1'b1;
                    end else begin
                        hb_instr_d = imem_rdata;
                        hb_pc4_d   = pc_inc;
                        hb_vld_d   = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (!stall_id) begin
                    flush = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    flush    = 1'b1;
                    hb_vld_d = 1'b0;
                    pc_d     = pc_align(redirect_pc);
                    state_d  = FETCH;
                end else if (!stall_id) begin
                    load     = hb_vld_q;
                    flush    = !hb_vld_q;
                    ld_instr = hb_instr_q;
                    ld_pc4   = hb_pc4_q;
                    hb_vld_d = 1'b0;
                    state_d  = FETCH;
                end
            end
            DRAIN: begin
                // IF/ID already holds a bubble; keep it one.
                flush = 1'b1;
                if (redirect) begin
                    tgt_d = pc_align(redirect_pc);
                    if (imem_ack) begin
                        pc_d    = pc_align(redirect_pc);
                        state_d = FETCH;
                    end
                end else if (imem_ack) begin
                    pc_d    = tgt_q;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC and hold buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            tgt_q      <= RESET_PC;
            hb_instr_q <= NOP;
            hb_pc4_q   <= 32'h0;
            hb_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tgt_q      <= tgt_d;
            hb_instr_q <= hb_instr_d;
            hb_pc4_q   <= hb_pc4_d;
            hb_vld_q   <= hb_vld_d;
        end
    end

    if_id_reg u_if_id (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush),
        .load_i  (load),
        .instr_i (ld_instr),
        .pc4_i   (ld_pc4),
        .instr_o (instruction),
        .pc4_o   (pc_plus4),
        .valid_o (id_valid)
    );

endmodule
